exc_commit: RTL and testbench
=============================

Name: exc_commit

Overview:
- Exception/ERET commit stage between the MEM-stage pipeline register and cp0_regfile.
- Prioritises the exception flags carried by the committing instruction plus the pending interrupt, then drives the CP0 write-side strobes (ex, excode, bd, pc, badvaddr, eret_flush).
- Issues a one-cycle pipeline flush and holds a PC redirect to fetch until fetch accepts it.

Parameters:
- EXC_VECTOR, 32'hBFC00380, exception entry PC (Status.BEV is fixed at 1).
- EXC_W, 8, width of the exception flag vector.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- ms_valid  in  1  MEM-stage instruction valid and ready to commit this cycle
- ms_pc  in  32  PC of committing instruction
- ms_bd  in  1  instruction is in a branch delay slot
- ms_exc  in  EXC_W  flags: [0] AdEL-fetch, [1] RI, [2] Ov, [3] Syscall, [4] Break, [5] AdEL-load, [6] AdES-store, [7] reserved (ignored)
- ms_data_vaddr  in  32  load/store virtual address
- ms_eret  in  1  instruction is ERET
- has_int  in  1  interrupt pending, from cp0_regfile
- epc  in  32  EPC value, from cp0_regfile
- ms_allowin  out  1  MEM stage may advance
- ex  out  1  exception commit strobe to CP0
- excode  out  5  ExcCode to CP0
- bd  out  1  BD to CP0
- m2s_pc  out  32  PC to CP0
- badvaddr  out  32  BadVAddr to CP0
- eret_flush  out  1  ERET commit strobe to CP0
- flush  out  1  kill all stages younger than commit
- redirect_valid  out  1  redirect request to fetch
- redirect_pc  out  32  redirect target
- redirect_ready  in  1  fetch accepts redirect

Behaviour:
- Reset (resetn low, asynchronous): state=IDLE; ex, eret_flush, flush and redirect_valid are 0; redirect_pc=0; excode=0. Takes effect immediately, including mid-REDIR; any pending redirect is dropped.
- States: IDLE and REDIR.
- Commit event, IDLE only: ms_valid=1 and (has_int or any ms_exc[6:0] or ms_eret).
- Exception priority, highest first: has_int (0x00), AdEL-fetch (0x04), RI (0x0a), Ov (0x0c), Syscall (0x08), Break (0x09), AdEL-load (0x04), AdES-store (0x05).
- Exception beats ERET: an ERET carrying a flag or with has_int is treated as an exception, and eret_flush stays 0.
- ex, excode, bd and m2s_pc are combinational on the event cycle and asserted for exactly one cycle. bd=ms_bd; m2s_pc=ms_pc, and cp0_regfile applies the -4 for BD itself.
- badvaddr: equals ms_pc for AdEL-fetch, ms_data_vaddr for AdEL-load/AdES-store, otherwise don't-care (drive ms_data_vaddr).
- ERET event: eret_flush=1 for one cycle; ex=0.
- flush=1 on the same cycle as ex or eret_flush.
- On the event clock edge: redirect_pc is registered (EXC_VECTOR for an exception, epc sampled that cycle for ERET); state goes to REDIR.
- REDIR: redirect_valid=1 with redirect_pc held stable.
  - On redirect_valid and redirect_ready: return to IDLE next cycle.
  - ms_allowin=0.
  - ms_valid is ignored; those are flushed instructions, so no strobes fire.
- IDLE, no event: ms_allowin=1 and all strobes 0.
- A back-to-back event is legal on the first IDLE cycle after REDIR.
- has_int is sampled only when ms_valid=1. An interrupt with no valid instruction waits.

Test Plan:
- Syscall commit: ms_valid=1, ms_pc=0xBFC00100, ms_exc[3]=1 → one-cycle ex=1, excode=0x08, flush=1. Next cycle redirect_valid=1, redirect_pc=0xBFC00380; held 3 cycles with redirect_ready=0, then released one cycle after redirect_ready=1.
- Priority: ms_exc has RI, Ov and AdES set together → excode=0x0a. Then ms_exc[0] with has_int=1 → excode=0x00.
- AdES in delay slot: ms_bd=1, ms_data_vaddr=0x80000003, ms_exc[6]=1 → ex=1, excode=0x05, bd=1, badvaddr=0x80000003. AdEL-fetch with ms_pc=0x80000002 → badvaddr=0x80000002.
- ERET: ms_eret=1, epc=0xBFC00480 → eret_flush=1, ex=0, flush=1, redirect_pc=0xBFC00480. ERET with has_int=1 → ex=1, excode=0x00, eret_flush=0.
- REDIR masking: ms_valid=1 with ms_exc[4]=1 while in REDIR → no ex and ms_allowin=0. The first IDLE-cycle event is then accepted.
- Async reset mid-REDIR: drop resetn between clock edges → redirect_valid falls to 0 immediately, state is IDLE after release, and no spurious strobes appear.

Source files
------------

// File: rtl/exc_commit_if.sv
// =============================================================================
// exc_commit_if : commit-stage bus (MEM-stage inputs, CP0 strobes, redirect)
// Rev 1.0
// =============================================================================
`default_nettype none

interface exc_commit_if #(
  parameter int EXC_W = 8
);
  // MEM-stage pipeline register side
  logic             ms_valid;
  logic [31:0]      ms_pc;
  logic             ms_bd;
  logic [EXC_W-1:0] ms_exc;
  logic [31:0]      ms_data_vaddr;
  logic             ms_eret;
  logic             ms_allowin;

  // cp0_regfile side
  logic             has_int;
  logic [31:0]      epc;
  logic             ex;
  logic [4:0]       excode;
  logic             bd;
  logic [31:0]      m2s_pc;
  logic [31:0]      badvaddr;
  logic             eret_flush;

  // pipeline control / fetch redirect
  logic             flush;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             redirect_ready;

  // master: pipeline, CP0 and fetch surrounding the commit stage
  modport master (
    output ms_valid, ms_pc, ms_bd, ms_exc, ms_data_vaddr, ms_eret,
    output has_int, epc, redirect_ready,
    input  ms_allowin, ex, excode, bd, m2s_pc, badvaddr, eret_flush,
    input  flush, redirect_valid, redirect_pc
  );

  // slave: the commit stage itself
  modport slave (
    input  ms_valid, ms_pc, ms_bd, ms_exc, ms_data_vaddr, ms_eret,
    input  has_int, epc, redirect_ready,
    output ms_allowin, ex, excode, bd, m2s_pc, badvaddr, eret_flush,
    output flush, redirect_valid, redirect_pc
  );
endinterface

`default_nettype wire

// File: rtl/exc_commit.sv
// =============================================================================
// exc_commit : exception / ERET commit stage, CP0 write strobes and redirect
// Rev 1.0
// =============================================================================
`default_nettype none

module exc_commit #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
  parameter int          EXC_W      = 8
) (
  input  wire logic     clk,
  input  wire logic     resetn,
  exc_commit_if.slave   bus
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_REDIR = 1'b1;

  localparam logic [4:0] C_EXC_INT  = 5'h00;
  localparam logic [4:0] C_EXC_ADEL = 5'h04;
  localparam logic [4:0] C_EXC_ADES = 5'h05;
  localparam logic [4:0] C_EXC_SYS  = 5'h08;
  localparam logic [4:0] C_EXC_BP   = 5'h09;
  localparam logic [4:0] C_EXC_RI   = 5'h0a;
  localparam logic [4:0] C_EXC_OV   = 5'h0c;

  logic [0:0]       state_q, state_d;
  logic [31:0]      redirect_pc_q, redirect_pc_d;

  logic [EXC_W-1:0] exc_vec;
  logic [6:0]       exc_flags;
  logic             unused_exc_hi;
  logic             can_commit;
  logic             exc_event;
  logic             eret_event;
  logic [4:0]       code_sel;
  logic [31:0]      badvaddr_sel;

  assign exc_vec       = bus.ms_exc;
  assign exc_flags     = exc_vec[6:0];
  assign unused_exc_hi = ^exc_vec[EXC_W-1:7];

  // Strobes are gated by resetn so nothing reaches CP0 while reset is held.
  assign can_commit = resetn && (state_q == ST_IDLE) && bus.ms_valid;
  assign exc_event  = can_commit && (bus.has_int || (|exc_flags));
  assign eret_event = can_commit && bus.ms_eret && !exc_event;

  // Priority order: interrupt first, then the flags from bit 0 upward.
  always_comb begin
    code_sel     = C_EXC_INT;
    badvaddr_sel = bus.ms_data_vaddr;
    if (bus.has_int) begin
      code_sel = C_EXC_INT;
    end else if (exc_flags[0]) begin
      code_sel     = C_EXC_ADEL;
      badvaddr_sel = bus.ms_pc;
    end else if (exc_flags[1]) begin
      code_sel = C_EXC_RI;
    end else if (exc_flags[2]) begin
      code_sel = C_EXC_OV;
    end else if (exc_flags[3]) begin
      code_sel = C_EXC_SYS;
    end else if (exc_flags[4]) begin
      code_sel = C_EXC_BP;
    end else if (exc_flags[5]) begin
      code_sel = C_EXC_ADEL;
    end else if (exc_flags[6]) begin
      code_sel = C_EXC_ADES;
    end
  end

  always_comb begin
    state_d       = state_q;
    redirect_pc_d = redirect_pc_q;
    case (state_q)
      ST_IDLE: begin
        if (exc_event) begin
          state_d       = ST_REDIR;
          redirect_pc_d = EXC_VECTOR;
        end else if (eret_event) begin
          state_d       = ST_REDIR;
          redirect_pc_d = bus.epc;
        end
      end
      ST_REDIR: begin
        if (bus.redirect_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      redirect_pc_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign bus.ex         = exc_event;
  assign bus.excode     = exc_event ? code_sel : 5'h00;
  assign bus.bd         = exc_event & bus.ms_bd;
  assign bus.m2s_pc     = exc_event ? bus.ms_pc : 32'h0;
  assign bus.badvaddr   = badvaddr_sel;
  assign bus.eret_flush = eret_event;
  assign bus.flush      = exc_event | eret_event;

  // Instructions arriving during REDIR are wrong-path and are held off.
  assign bus.ms_allowin     = (state_q == ST_IDLE);
  assign bus.redirect_valid = (state_q == ST_REDIR);
  assign bus.redirect_pc    = redirect_pc_q;

endmodule

`default_nettype wire

// File: tb/tb_exc_commit.sv
// =============================================================================
// tb_exc_commit : directed + random bench for exc_commit with reference model
// Rev 1.0
// =============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_exc_commit;

  localparam logic [31:0] VEC = 32'hBFC00380;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  exc_commit_if #(.EXC_W(8)) bus ();

  exc_commit #(.EXC_VECTOR(VEC), .EXC_W(8)) u_dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  // reference model: a redirect is either pending (with its target) or not
  bit          m_redir;
  logic [31:0] m_rpc;
  logic [4:0]  code_tab [7] = '{5'h04, 5'h0a, 5'h0c, 5'h08, 5'h09, 5'h04, 5'h05};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic bdi,
                       input logic [7:0] exc, input logic [31:0] va, input logic er,
                       input logic hi, input logic [31:0] ep, input logic rr);
    bus.ms_valid       = v;
    bus.ms_pc          = pc;
    bus.ms_bd          = bdi;
    bus.ms_exc         = exc;
    bus.ms_data_vaddr  = va;
    bus.ms_eret        = er;
    bus.has_int        = hi;
    bus.epc            = ep;
    bus.redirect_ready = rr;
  endtask

  // one clock: drive at posedge+1, check at negedge, advance model at posedge
  task automatic cyc(input logic v, input logic [31:0] pc, input logic bdi,
                     input logic [7:0] exc, input logic [31:0] va, input logic er,
                     input logic hi, input logic [31:0] ep, input logic rr);
    int   first;
    bit   exc_ev, eret_ev;
    logic [4:0] code;
    drive(v, pc, bdi, exc, va, er, hi, ep, rr);
    @(negedge clk);
    first = -1;
    for (int i = 0; i < 7; i++) if (exc[i] && first < 0) first = i;
    exc_ev  = !m_redir && v && (hi || first >= 0);
    eret_ev = !m_redir && v && er && !exc_ev;
    code    = hi ? 5'h00 : ((first >= 0) ? code_tab[first] : 5'h00);
    check("ex",         {31'b0, bus.ex},         {31'b0, exc_ev});
    check("eret_flush", {31'b0, bus.eret_flush}, {31'b0, eret_ev});
    check("flush",      {31'b0, bus.flush},      {31'b0, exc_ev || eret_ev});
    check("allowin",    {31'b0, bus.ms_allowin}, {31'b0, !m_redir});
    check("redir_vld",  {31'b0, bus.redirect_valid}, {31'b0, m_redir});
    if (m_redir) check("redir_pc", bus.redirect_pc, m_rpc);
    if (exc_ev) begin
      check("excode", {27'b0, bus.excode}, {27'b0, code});
      check("bd",     {31'b0, bus.bd},     {31'b0, bdi});
      check("m2s_pc", bus.m2s_pc, pc);
      if (!hi && first == 0) check("badva_fetch", bus.badvaddr, pc);
      if (!hi && first >= 5) check("badva_data",  bus.badvaddr, va);
    end
    @(posedge clk);
    if (exc_ev) begin
      m_redir = 1'b1;
      m_rpc   = VEC;
    end else if (eret_ev) begin
      m_redir = 1'b1;
      m_rpc   = ep;
    end else if (m_redir && rr) begin
      m_redir = 1'b0;
    end
    #1;
  endtask

  task automatic idle(input logic rr);
    cyc(1'b0, 32'h0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 32'h0, rr);
  endtask

  initial begin
    m_redir = 1'b0;
    m_rpc   = 32'h0;
    resetn  = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("rst_ex",     {31'b0, bus.ex},             32'h0);
    check("rst_eret",   {31'b0, bus.eret_flush},     32'h0);
    check("rst_flush",  {31'b0, bus.flush},          32'h0);
    check("rst_rvld",   {31'b0, bus.redirect_valid}, 32'h0);
    check("rst_rpc",    bus.redirect_pc,             32'h0);
    check("rst_excode", {27'b0, bus.excode},         32'h0);
    @(posedge clk);
    #1 resetn = 1'b1;

    // syscall, redirect held three cycles, released after ready
    cyc(1'b1, 32'hBFC00100, 1'b0, 8'h08, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    repeat (3) idle(1'b0);
    idle(1'b1);
    idle(1'b0);

    // priority: RI|Ov|AdES -> RI; AdEL-fetch with interrupt -> Int
    cyc(1'b1, 32'h80001000, 1'b0, 8'h46, 32'h12345678, 1'b0, 1'b0, 32'h0, 1'b0);
    idle(1'b1);
    cyc(1'b1, 32'h80001004, 1'b0, 8'h01, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1);
    idle(1'b1);

    // AdES in delay slot, AdEL-fetch badvaddr
    cyc(1'b1, 32'h80002000, 1'b1, 8'h40, 32'h80000003, 1'b0, 1'b0, 32'h0, 1'b1);
    idle(1'b1);
    cyc(1'b1, 32'h80000002, 1'b0, 8'h01, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 1'b1);
    idle(1'b1);

    // ERET plain, then ERET overridden by interrupt
    cyc(1'b1, 32'h80003000, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 32'hBFC00480, 1'b0);
    idle(1'b1);
    cyc(1'b1, 32'h80003004, 1'b0, 8'h00, 32'h0, 1'b1, 1'b1, 32'hBFC00480, 1'b1);
    idle(1'b1);

    // reserved flag alone is not an event; interrupt without valid waits
    cyc(1'b1, 32'h80004000, 1'b0, 8'h80, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 32'h80004004, 1'b0, 8'h00, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);

    // REDIR masking, then back-to-back event on the first IDLE cycle
    cyc(1'b1, 32'h80005000, 1'b0, 8'h08, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 32'h80005004, 1'b0, 8'h10, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b1, 32'h80005004, 1'b0, 8'h10, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    idle(1'b1);

    // asynchronous reset while a redirect is pending
    cyc(1'b1, 32'h80006000, 1'b0, 8'h08, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("pre_rst_rvld", {31'b0, bus.redirect_valid}, 32'h1);
    #1 resetn = 1'b0;
    #1;
    check("arst_rvld",  {31'b0, bus.redirect_valid}, 32'h0);
    check("arst_rpc",   bus.redirect_pc,             32'h0);
    check("arst_flush", {31'b0, bus.flush},          32'h0);
    m_redir = 1'b0;
    m_rpc   = 32'h0;
    #1 resetn = 1'b1;
    idle(1'b0);
    cyc(1'b1, 32'h80006010, 1'b0, 8'h10, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    idle(1'b1);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [7:0] ex_r;
      ex_r = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      cyc(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), ex_r, $urandom,
          ($urandom_range(0, 4) == 0), ($urandom_range(0, 6) == 0), $urandom,
          ($urandom_range(0, 2) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule

`default_nettype wire
